jh_adc_bus_arbiter: RTL

JH_ADC_BUS_ARBITER -- requirements
Module: jh_adc_bus_arbiter

---
 rtl/jh_adc_bus_arbiter.sv | 138 +++++++++++++
 1 files changed

// File: rtl/jh_adc_bus_arbiter.sv
// Two-requester round-robin arbiter sharing one Avalon-style ADC bus.
// Optional stall watchdog that aborts a hung owner: define JH_ARB_TIMEOUT_EN.
module jh_adc_bus_arbiter #(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int TO_W           = 11
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] m0_addr,
    input  logic [3:0]  m0_byte_enable,
    input  logic        m0_read,
    input  logic        m0_write,
    input  logic [15:0] m0_write_data,
    output logic        m0_ack,
    output logic [15:0] m0_read_data,
    input  logic [15:0] m1_addr,
    input  logic [3:0]  m1_byte_enable,
    input  logic        m1_read,
    input  logic        m1_write,
    input  logic [15:0] m1_write_data,
    output logic        m1_ack,
    output logic [15:0] m1_read_data,
    output logic [15:0] s_addr,
    output logic [3:0]  s_byte_enable,
    output logic        s_read,
    output logic        s_write,
    output logic [15:0] s_write_data,
    input  logic        s_ack,
    input  logic [15:0] s_read_data,
    output logic [1:0]  grant,
    output logic        timeout_err
);

    // state | meaning
    // IDLE  | bus parked, all s_* driven low, arbitration happens here
    // OWN0  | m0 owns the bus until it drops its request (or is aborted)
    // OWN1  | m1 owns the bus until it drops its request (or is aborted)
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        OWN0 = 2'b01,
        OWN1 = 2'b10
    } state_t;

    state_t state;
    logic   last_grant;
    logic   req0;
    logic   req1;
    logic   own_req;
    logic   abort;

    if (2**TO_W <= TIMEOUT_CYCLES) begin : g_bad_to_w
        $error("TO_W is too narrow to hold TIMEOUT_CYCLES");
    end

    assign req0    = m0_read | m0_write;
    assign req1    = m1_read | m1_write;
    assign own_req = (state == OWN0) ? req0 : req1;
    assign grant   = state;

`ifdef JH_ARB_TIMEOUT_EN
    logic [TO_W-1:0] to_cnt;

    assign abort = (state != IDLE) && (to_cnt == TO_W'(TIMEOUT_CYCLES));

    always_ff @(posedge clock) begin
        if (reset || state == IDLE || abort || !own_req || s_ack) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + 1'b1;
        end
    end
`else
    assign abort = 1'b0;
`endif

    // last_grant = 1 means m1 was served last, so m0 wins the next tie.
    // After an abort the aborted owner is last_grant, so the other side wins.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (req0 && (!req1 || last_grant)) begin
                        state      <= OWN0;
                        last_grant <= 1'b0;
                    end else if (req1) begin
                        state      <= OWN1;
                        last_grant <= 1'b1;
                    end
                end
                OWN0:    if (!req0 || abort) state <= IDLE;
                OWN1:    if (!req1 || abort) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs are gated by reset so an ack landing in the reset cycle is dropped.
    always_comb begin
        s_addr        = '0;
        s_byte_enable = '0;
        s_read        = 1'b0;
        s_write       = 1'b0;
        s_write_data  = '0;
        m0_ack        = 1'b0;
        m0_read_data  = '0;
        m1_ack        = 1'b0;
        m1_read_data  = '0;
        timeout_err   = 1'b0;
        if (!reset) begin
            timeout_err = abort;
            case (state)
                OWN0: begin
                    s_addr        = m0_addr;
                    s_byte_enable = m0_byte_enable;
                    s_read        = m0_read;
                    s_write       = m0_write;
                    s_write_data  = m0_write_data;
                    m0_ack        = s_ack | abort;
                    m0_read_data  = abort ? 16'h0000 : s_read_data;
                end
                OWN1: begin
                    s_addr        = m1_addr;
                    s_byte_enable = m1_byte_enable;
                    s_read        = m1_read;
                    s_write       = m1_write;
                    s_write_data  = m1_write_data;
                    m1_ack        = s_ack | abort;
                    m1_read_data  = abort ? 16'h0000 : s_read_data;
                end
                default: ;
            endcase
        end
    end

endmodule
